// File: rtl/mem_lsu_adapter_if.sv
// rtl/mem_lsu_adapter_if.sv - core request/response and memory port 2 signal bundle
interface mem_lsu_adapter_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_put_valid;
  logic        mem_put_ready;
  logic [67:0] mem_put_request;
  logic        mem_get_valid;
  logic        mem_get_ready;
  logic [67:0] mem_get_response;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_put_ready, mem_get_ready, mem_get_response,
    output req_ready, resp_valid, resp_data, resp_err,
    output mem_put_valid, mem_put_request, mem_get_valid
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_put_ready, mem_get_ready, mem_get_response,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  mem_put_valid, mem_put_request, mem_get_valid
  );
endinterface

// File: rtl/mem_lsu_adapter.sv
// rtl/mem_lsu_adapter.sv - load/store front end with in-order metadata FIFO
module mem_lsu_adapter #(
  parameter int META_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_lsu_adapter_if.slave  bus_if
);
  localparam int PW = (META_DEPTH > 1) ? $clog2(META_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(META_DEPTH);

  typedef struct packed {
    logic       err;
    logic       write;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
  } meta_t;

  meta_t         meta_q [META_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  logic [1:0]  off;
  logic        req_err, full, empty, push, pop;
  logic        req_ready_w, resp_valid_w;
  logic [3:0]  byte_en;
  logic [31:0] shifted, load_data;
  meta_t       new_meta, head;

  assign off     = bus_if.req_addr[1:0];
  assign req_err = (bus_if.req_size == 2'd3)
                 | ((bus_if.req_size == 2'd1) & off[0])
                 | ((bus_if.req_size == 2'd2) & (off != 2'd0));
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);

  // Errors bypass memory, so they only need FIFO room to be accepted.
  assign req_ready_w          = !rst_i & !full & (req_err | bus_if.mem_put_ready);
  assign bus_if.req_ready     = req_ready_w;
  assign bus_if.mem_put_valid = bus_if.req_valid & !rst_i & !full & !req_err;
  assign push                 = bus_if.req_valid & req_ready_w;

  always_comb begin
    byte_en = 4'b0000;
    if (bus_if.req_write) begin
      case (bus_if.req_size)
        2'd0:    byte_en = 4'b0001 << off;
        2'd1:    byte_en = 4'b0011 << off;
        default: byte_en = 4'b1111;
      endcase
    end
  end

  assign bus_if.mem_put_request = bus_if.req_write
      ? {byte_en, bus_if.req_addr[31:2], 2'b00, bus_if.req_wdata << {off, 3'b000}}
      : {4'b0000, bus_if.req_addr[31:2], 2'b00, 32'h0};

  assign new_meta = '{err: req_err, write: bus_if.req_write, size: bus_if.req_size,
                      uns: bus_if.req_unsigned, off: off};

  assign head = meta_q[rd_ptr_q];

  // Non-error heads ride the memory handshake so the memory slot frees in the same cycle.
  assign resp_valid_w         = !rst_i & !empty & (head.err | bus_if.mem_get_ready);
  assign bus_if.resp_valid    = resp_valid_w;
  assign bus_if.mem_get_valid = !rst_i & !empty & !head.err & bus_if.resp_ready;
  assign bus_if.resp_err      = !rst_i & !empty & head.err;
  assign pop                  = resp_valid_w & bus_if.resp_ready;

  assign shifted = bus_if.mem_get_response[31:0] >> {head.off, 3'b000};

  always_comb begin
    case (head.size)
      2'd0:    load_data = {{24{~head.uns & shifted[7]}},  shifted[7:0]};
      2'd1:    load_data = {{16{~head.uns & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign bus_if.resp_data = (head.err | head.write | empty) ? 32'h0 : load_data;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      meta_q[wr_ptr_q] <= new_meta;
    end
  end
endmodule

// File: tb/tb_mem_lsu_adapter.sv
// tb/tb_mem_lsu_adapter.sv - self-checking bench with a port-2 memory model and response scoreboard
module tb_mem_lsu_adapter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_lsu_adapter_if bus ();

  mem_lsu_adapter #(.META_DEPTH(2)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus)
  );

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_pdata;
    logic [31:0] exp_resp;
  } vec_t;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int push_cnt = 0;
  int pop_cnt  = 0;
  int max_out  = 0;
  logic [32:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory port model: one response slot, freed in the same cycle it is taken.
  logic        mem_has;
  logic [67:0] mem_rsp;
  logic [31:0] mem_words [0:255];

  assign bus.mem_put_ready    = !mem_has || bus.mem_get_valid;
  assign bus.mem_get_ready    = mem_has;
  assign bus.mem_get_response = mem_rsp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_has <= 1'b0;
      mem_rsp <= '0;
      for (int i = 0; i < 256; i++) mem_words[i] <= 32'h0;
      mem_words[0]   <= 32'h11111111;
      mem_words[1]   <= 32'h22222222;
      mem_words[2]   <= 32'h33333333;
      mem_words[64]  <= 32'h12F45678;
      mem_words[193] <= 32'h80000001;
    end else begin
      if (bus.mem_get_valid && mem_has) mem_has <= 1'b0;
      if (bus.mem_put_valid && bus.mem_put_ready) begin
        mem_rsp <= {bus.mem_put_request[67:32], mem_words[bus.mem_put_request[41:34]]};
        for (int b = 0; b < 4; b++)
          if (bus.mem_put_request[64+b])
            mem_words[bus.mem_put_request[41:34]][8*b +: 8] <= bus.mem_put_request[8*b +: 8];
        mem_has <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.resp_valid && bus.resp_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_resp");
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("resp_data", bus.resp_data, e[31:0]);
          chk("resp_err", {31'h0, bus.resp_err}, {31'h0, e[32]});
        end
        pop_cnt++;
      end
      if (!rst && bus.mem_get_ready && bus.resp_valid && bus.resp_err)
        fail_now("get_ready_on_err_head");
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance with req_valid still high.
  task automatic issue(input vec_t v, output int acc_cyc);
    bus.req_valid    = 1'b1;
    bus.req_write    = v.write;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    acc_cyc = -1;
    for (int t = 0; t < 50 && acc_cyc < 0; t++) begin
      #1;
      if (bus.req_ready) begin
        chk("put_valid", {31'h0, bus.mem_put_valid}, {31'h0, !v.exp_err});
        if (!v.exp_err) begin
          chk("put_be",    {28'h0, bus.mem_put_request[67:64]}, {28'h0, v.exp_be});
          chk("put_addr",  bus.mem_put_request[63:32], {v.addr[31:2], 2'b00});
          chk("put_data",  bus.mem_put_request[31:0], v.exp_pdata);
        end
        exp_q.push_back({v.exp_err, v.exp_resp});
        push_cnt++;
        if (push_cnt - pop_cnt > max_out) max_out = push_cnt - pop_cnt;
        acc_cyc = cyc;
      end
      @(negedge clk);
    end
    if (acc_cyc < 0) fail_now("accept_timeout");
  endtask

  task automatic drain();
    bus.req_valid = 1'b0;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic u,
                              input logic [31:0] a, input logic [31:0] wd, input logic e,
                              input logic [3:0] be, input logic [31:0] pd, input logic [31:0] r);
    vec_t v;
    v.write = w; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
    v.exp_err = e; v.exp_be = be; v.exp_pdata = pd; v.exp_resp = r;
    return v;
  endfunction

  vec_t tbl [16];

  initial begin
    int c0, c1, c2, cx;
    vec_t v;

    tbl[0]  = mk(1, 0, 0, 32'h103, 32'h000000AB, 0, 4'b1000, 32'hAB000000, 32'h0);
    tbl[1]  = mk(0, 0, 0, 32'h102, 32'h0,        0, 4'b0000, 32'h0,        32'hFFFFFFF4);
    tbl[2]  = mk(0, 0, 1, 32'h102, 32'h0,        0, 4'b0000, 32'h0,        32'h000000F4);
    tbl[3]  = mk(1, 1, 0, 32'h202, 32'h0000BEEF, 0, 4'b1100, 32'hBEEF0000, 32'h0);
    tbl[4]  = mk(0, 1, 0, 32'h202, 32'h0,        0, 4'b0000, 32'h0,        32'hFFFFBEEF);
    tbl[5]  = mk(0, 1, 1, 32'h202, 32'h0,        0, 4'b0000, 32'h0,        32'h0000BEEF);
    tbl[6]  = mk(0, 1, 0, 32'h201, 32'h0,        1, 4'b0000, 32'h0,        32'h0);
    tbl[7]  = mk(0, 2, 0, 32'h103, 32'h0,        1, 4'b0000, 32'h0,        32'h0);
    tbl[8]  = mk(1, 3, 0, 32'h100, 32'h5,        1, 4'b0000, 32'h0,        32'h0);
    tbl[9]  = mk(1, 2, 0, 32'h300, 32'hCAFEF00D, 0, 4'b1111, 32'hCAFEF00D, 32'h0);
    tbl[10] = mk(0, 2, 0, 32'h300, 32'h0,        0, 4'b0000, 32'h0,        32'hCAFEF00D);
    tbl[11] = mk(0, 0, 0, 32'h301, 32'h0,        0, 4'b0000, 32'h0,        32'hFFFFFFF0);
    tbl[12] = mk(1, 0, 0, 32'h300, 32'h000001FF, 0, 4'b0001, 32'h000001FF, 32'h0);
    tbl[13] = mk(0, 0, 1, 32'h300, 32'h0,        0, 4'b0000, 32'h0,        32'h000000FF);
    tbl[14] = mk(0, 2, 0, 32'h304, 32'h0,        0, 4'b0000, 32'h0,        32'h80000001);
    tbl[15] = mk(0, 1, 0, 32'h300, 32'h0,        0, 4'b0000, 32'h0,        32'hFFFFF0FF);

    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.resp_ready = 1'b1;

    fork monitor(); join_none

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready",     {31'h0, bus.req_ready},     32'h0);
    chk("rst_put_valid",     {31'h0, bus.mem_put_valid}, 32'h0);
    chk("rst_resp_valid",    {31'h0, bus.resp_valid},    32'h0);
    chk("rst_get_valid",     {31'h0, bus.mem_get_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      issue(tbl[i], cx);
      bus.req_valid = 1'b0;
    end
    drain();

    // Error response on the cycle after acceptance.
    issue(tbl[6], cx);
    bus.req_valid = 1'b0;
    #2;
    chk("err_next_valid", {31'h0, bus.resp_valid}, 32'h1);
    chk("err_next_flag",  {31'h0, bus.resp_err},   32'h1);
    drain();

    // Error queued behind a pending word load; FIFO fills and blocks without bypass.
    bus.resp_ready = 1'b0;
    issue(mk(0, 2, 0, 32'h300, 32'h0, 0, 4'b0000, 32'h0, 32'hCAFEF0FF), cx);
    issue(tbl[6], cx);
    v = mk(0, 2, 0, 32'h000, 32'h0, 0, 4'b0000, 32'h0, 32'h11111111);
    bus.req_addr = 32'h0; bus.req_size = 2'd2; bus.req_write = 1'b0;
    #1;
    chk("full_blocks", {31'h0, bus.req_ready}, 32'h0);
    @(negedge clk);
    bus.resp_ready = 1'b1;
    #1;
    chk("no_bypass_on_pop", {31'h0, bus.req_ready}, 32'h0);
    @(negedge clk);
    issue(v, cx);
    drain();

    // Back-to-back word loads at full throughput.
    max_out = 0;
    issue(mk(0, 2, 0, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h11111111), c0);
    issue(mk(0, 2, 0, 32'h4, 32'h0, 0, 4'b0000, 32'h0, 32'h22222222), c1);
    issue(mk(0, 2, 0, 32'h8, 32'h0, 0, 4'b0000, 32'h0, 32'h33333333), c2);
    chk("b2b_gap1", c1 - c0, 32'd1);
    chk("b2b_gap2", c2 - c1, 32'd1);
    drain();
    chk("max_outstanding_le2", {31'h0, (max_out <= 2)}, 32'h1);

    // Reset mid-stream.
    bus.resp_ready = 1'b0;
    issue(mk(0, 2, 0, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h11111111), cx);
    issue(tbl[7], cx);
    bus.req_addr = 32'h8; bus.req_size = 2'd2; bus.req_write = 1'b0;
    bus.resp_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_req_ready",  {31'h0, bus.req_ready},     32'h0);
    chk("midrst_put_valid",  {31'h0, bus.mem_put_valid}, 32'h0);
    chk("midrst_resp_valid", {31'h0, bus.resp_valid},    32'h0);
    chk("midrst_get_valid",  {31'h0, bus.mem_get_valid}, 32'h0);
    exp_q.delete();
    push_cnt = pop_cnt;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("postrst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("postrst_req_ready",  {31'h0, bus.req_ready},  32'h1);
    @(negedge clk);
    issue(tbl[14], cx);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
